exc_redirect_ctrl: RTL and testbench

Sequences the front-end redirect that follows an exception or ERET. It sits between the exception unit and the fetch stage. It takes the one-cycle redirect request and target PC from the exception unit and holds the pipeline flush. It blocks new instruction-SRAM requests and drains responses already in flight, discarding them. It then hands the target PC to fetch over a valid/ready handshake.

---
 rtl/exc_ctrl_pkg.sv | 13 +
 rtl/inst_outstanding_cnt.sv | 47 ++++
 rtl/exc_redirect_ctrl.sv | 114 +++++++++++
 tb/tb_exc_redirect_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared types and defaults for the exception/ERET front-end redirect controller.
package exc_ctrl_pkg;

  // Default depth of the instruction-SRAM request pipeline.
  localparam int unsigned MAX_OUTSTANDING_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } redir_state_t;

endpackage

// File: rtl/inst_outstanding_cnt.sv
// Saturating up/down counter of instruction-SRAM requests still in flight.
// Never wraps: a decrement at zero is dropped, as is an increment at MAX_OUTSTANDING.
module inst_outstanding_cnt
  import exc_ctrl_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic          o_full,
  output logic [CW-1:0] o_cnt_next
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_inc;
  logic          w_dec;

  assign o_full = (r_cnt == CW'(MAX_OUTSTANDING));
  assign w_inc  = i_inc && !o_full;
  assign w_dec  = i_dec && (r_cnt != '0);

  // Next count; a simultaneous accepted increment and decrement cancel out.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_inc && !w_dec) begin
      w_cnt_next = r_cnt + CW'(1);
    end else if (w_dec && !w_inc) begin
      w_cnt_next = r_cnt - CW'(1);
    end
  end

  assign o_cnt_next = w_cnt_next;

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Front-end redirect sequencer for exceptions and ERET: holds the flush,
// blocks new fetches, drains and discards in-flight responses, then hands
// the target PC to fetch over valid/ready.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | no redirect pending; fetch runs normally
//   DRAIN    | flush held, waiting for in-flight responses to return
//   REDIRECT | flush held, redirect_pc offered to fetch until accepted
module exc_redirect_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        inst_req_fire,
  input  logic        inst_data_ok,
  input  logic        fetch_ready,
  output logic        inst_req_allow,
  output logic        flush,
  output logic        discard_resp,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  redir_state_t  r_state;
  logic [31:0]   r_redirect_pc;
  logic          r_flush;
  logic          r_redirect_valid;
  logic          w_full;
  logic [CW-1:0] w_cnt_next;
  logic          w_drained;

  inst_outstanding_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (inst_req_fire),
    .i_dec      (inst_data_ok),
    .o_full     (w_full),
    .o_cnt_next (w_cnt_next)
  );

  assign w_drained = (w_cnt_next == '0);

  // Redirect sequencing; flush and redirect_valid are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_redirect_pc    <= 32'h0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (exc_req) begin
            r_redirect_pc <= exc_pc;
            r_flush       <= 1'b1;
            if (w_drained) begin
              r_state          <= REDIRECT;
              r_redirect_valid <= 1'b1;
            end else begin
              r_state          <= DRAIN;
              r_redirect_valid <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (exc_req) begin
            r_redirect_pc <= exc_pc;
          end
          if (w_drained) begin
            r_state          <= REDIRECT;
            r_redirect_valid <= 1'b1;
          end
        end
        REDIRECT: begin
          // A new request during the offer (accepted or not) re-arms with the newer PC.
          if (exc_req) begin
            r_redirect_pc <= exc_pc;
          end else if (fetch_ready) begin
            r_state          <= IDLE;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
          end
        end
        default: begin
          r_state          <= IDLE;
          r_flush          <= 1'b0;
          r_redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  // Responses are only squashed while draining; the exc_req cycle is covered by the downstream flush.
  always_comb begin
    inst_req_allow = (r_state == IDLE) && !exc_req && !w_full;
    discard_resp   = (r_state == DRAIN) && inst_data_ok;
  end

  assign flush          = r_flush;
  assign busy           = r_flush;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Self-checking bench for exc_redirect_ctrl: cycle-by-cycle vector table with
// a scoreboard queue, plus a hand-written bounded drain/handshake sequence.
module tb_exc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_req = 1'b0;
  logic [31:0] exc_pc = 32'h0;
  logic        inst_req_fire = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        inst_req_allow;
  logic        flush;
  logic        discard_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  exc_redirect_ctrl #(.MAX_OUTSTANDING(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .exc_req        (exc_req),
    .exc_pc         (exc_pc),
    .inst_req_fire  (inst_req_fire),
    .inst_data_ok   (inst_data_ok),
    .fetch_ready    (fetch_ready),
    .inst_req_allow (inst_req_allow),
    .flush          (flush),
    .discard_resp   (discard_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        exc;
    logic [31:0] pc;
    logic        fire;
    logic        ok;
    logic        rdy;
    logic        allow;
    logic        flush;
    logic        disc;
    logic        rv;
    logic [31:0] rpc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(logic r, logic e, logic [31:0] p, logic f, logic o, logic y,
                              logic a, logic fl, logic d, logic v, logic [31:0] rp);
    vec_t t;
    t.rst = r; t.exc = e; t.pc = p; t.fire = f; t.ok = o; t.rdy = y;
    t.allow = a; t.flush = fl; t.disc = d; t.rv = v; t.rpc = rp;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [31:0] p,
                       input logic f, input logic o, input logic y);
    rst = r; exc_req = e; exc_pc = p; inst_req_fire = f; inst_data_ok = o; fetch_ready = y;
  endtask

  initial begin
    vec_t e;
    int   hit;
    //          rst exc pc            fire ok rdy | allow flush disc rv pc
    // reset and idle
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 32'h0));
    // idle redirect, nothing in flight
    vecs.push_back(mk(0, 1, 32'hBFC00380, 0, 0, 1,  0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1,  0, 1, 0, 1, 32'hBFC00380));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 32'hBFC00380));
    // drain three outstanding responses
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 0, 32'hBFC00380));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 0, 32'hBFC00380));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 0, 32'hBFC00380));
    vecs.push_back(mk(0, 1, 32'h10000040, 0, 0, 0,  0, 0, 0, 0, 32'hBFC00380));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 1, 0, 0, 32'h10000040));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0,  0, 1, 1, 0, 32'h10000040));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 1, 0, 0, 32'h10000040));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0,  0, 1, 1, 0, 32'h10000040));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0,  0, 1, 1, 0, 32'h10000040));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 1, 0, 1, 32'h10000040));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 1, 0, 1, 32'h10000040));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1,  0, 1, 0, 1, 32'h10000040));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 32'h10000040));
    // fire and response together with exc_req, cnt stays 1
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 0, 32'h10000040));
    vecs.push_back(mk(0, 1, 32'h20000000, 1, 1, 0,  0, 0, 0, 0, 32'h10000040));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 1, 0, 0, 32'h20000000));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0,  0, 1, 1, 0, 32'h20000000));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1,  0, 1, 0, 1, 32'h20000000));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 32'h20000000));
    // override during DRAIN: later request wins
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 0, 32'h20000000));
    vecs.push_back(mk(0, 1, 32'hBFC00380, 0, 0, 0,  0, 0, 0, 0, 32'h20000000));
    vecs.push_back(mk(0, 1, 32'h80001000, 0, 0, 0,  0, 1, 0, 0, 32'hBFC00380));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 1, 0, 0, 32'h80001000));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0,  0, 1, 1, 0, 32'h80001000));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1,  0, 1, 0, 1, 32'h80001000));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 32'h80001000));
    // REDIRECT overwrite without ready, then back-to-back in the handshake cycle
    vecs.push_back(mk(0, 1, 32'h00000100, 0, 0, 0,  0, 0, 0, 0, 32'h80001000));
    vecs.push_back(mk(0, 1, 32'h00000200, 0, 0, 0,  0, 1, 0, 1, 32'h00000100));
    vecs.push_back(mk(0, 1, 32'h0000000A, 0, 0, 1,  0, 1, 0, 1, 32'h00000200));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 1, 0, 1, 32'h0000000A));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1,  0, 1, 0, 1, 32'h0000000A));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 32'h0000000A));
    // saturation at 4, fire at max ignored
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 0, 32'h0000000A));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 0, 32'h0000000A));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 0, 32'h0000000A));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 0, 32'h0000000A));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 0, 0, 0, 32'h0000000A));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  0, 0, 0, 0, 32'h0000000A));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0,  0, 0, 0, 0, 32'h0000000A));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 32'h0000000A));
    // reset in DRAIN, then response at cnt 0 is ignored
    vecs.push_back(mk(0, 1, 32'h00000300, 0, 0, 0,  0, 0, 0, 0, 32'h0000000A));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  0, 1, 0, 0, 32'h00000300));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0,  1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h00000400, 0, 0, 0,  0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1,  0, 1, 0, 1, 32'h00000400));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 32'h00000400));
    // last response arriving with exc_req goes straight to REDIRECT, not discarded
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 0, 32'h00000400));
    vecs.push_back(mk(0, 1, 32'h00000500, 0, 1, 0,  0, 0, 0, 0, 32'h00000400));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1,  0, 1, 0, 1, 32'h00000500));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0,  1, 0, 0, 0, 32'h00000500));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].exc, vecs[i].pc, vecs[i].fire, vecs[i].ok, vecs[i].rdy);
      sb.push_back(vecs[i]);
      #2;
      e = sb.pop_front();
      chk($sformatf("v%0d allow", i), {31'b0, inst_req_allow}, {31'b0, e.allow});
      chk($sformatf("v%0d flush", i), {31'b0, flush},          {31'b0, e.flush});
      chk($sformatf("v%0d busy", i),  {31'b0, busy},           {31'b0, e.flush});
      chk($sformatf("v%0d discard", i), {31'b0, discard_resp}, {31'b0, e.disc});
      chk($sformatf("v%0d rvalid", i), {31'b0, redirect_valid}, {31'b0, e.rv});
      chk($sformatf("v%0d rpc", i),   redirect_pc,             e.rpc);
    end

    // two in flight, exc_req, responses on the next two cycles; offer must appear on the third
    @(negedge clk); drive(0, 0, 32'h0, 1, 0, 0);
    @(negedge clk); drive(0, 0, 32'h0, 1, 0, 0);
    @(negedge clk); drive(0, 1, 32'h00000600, 0, 0, 0);
    hit = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      drive(0, 0, 32'h0, 0, (k <= 2), 1);
      #2;
      if (k <= 2) chk($sformatf("seq discard k%0d", k), {31'b0, discard_resp}, 32'h1);
      if (redirect_valid) begin
        hit = k;
        chk("seq rpc", redirect_pc, 32'h00000600);
        break;
      end
    end
    chk("seq offer cycle", hit, 3);
    @(negedge clk); drive(0, 0, 32'h0, 0, 0, 0);
    #2;
    chk("seq idle flush", {31'b0, flush}, 32'h0);
    chk("seq idle allow", {31'b0, inst_req_allow}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
